// File: rtl/lsu_responder.sv
// Single-outstanding LSU bridge onto a gnt/rvalid memory port, with timeout.
// Define LSU_RESP_MISALIGN_EN to reject misaligned half/word accesses.
module lsu_responder #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_ren,
    input  logic        lsu_wen,
    input  logic [1:0]  lsu_type,
    input  logic [31:0] lsu_addr_base,
    input  logic [31:0] lsu_addr_offset,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RVALID,
        RESP
    } state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [1:0]  lane;
    logic [1:0]  size;

    logic [31:0] req_addr;
    logic [31:0] req_addr_al;
    logic        req_misal;
    logic        req_bad;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;

    always_comb begin
        req_addr  = lsu_addr_base + lsu_addr_offset;
        req_misal = ((lsu_type == 2'b01) && req_addr[0])
                  || ((lsu_type == 2'b10) && (req_addr[1:0] != 2'b00));
        req_bad   = (lsu_ren && lsu_wen) || (lsu_type == 2'b11);
        req_addr_al = req_addr;
`ifdef LSU_RESP_MISALIGN_EN
        req_bad = req_bad || req_misal;
`else
        // Misaligned accesses are silently rounded down to their natural size.
        if (req_misal) begin
            if (lsu_type == 2'b01)
                req_addr_al[0] = 1'b0;
            else
                req_addr_al[1:0] = 2'b00;
        end
`endif
        unique case (1'b1)
            lsu_type == 2'b00: begin
                req_be    = 4'b0001 << req_addr_al[1:0];
                req_wdata = {4{lsu_wdata[7:0]}};
            end
            lsu_type == 2'b01: begin
                req_be    = 4'b0011 << req_addr_al[1:0];
                req_wdata = {2{lsu_wdata[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = lsu_wdata;
            end
        endcase
    end

    always_comb begin
        rd_shift = mem_rdata >> {lane, 3'b000};
        unique case (1'b1)
            size == 2'b00: rd_ext = {24'h0, rd_shift[7:0]};
            size == 2'b01: rd_ext = {16'h0, rd_shift[15:0]};
            default:       rd_ext = rd_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lane      <= 2'b00;
            size      <= 2'b00;
            lsu_done  <= 1'b0;
            lsu_err   <= 1'b0;
            lsu_rdata <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
        end else begin
            lsu_done  <= 1'b0;
            lsu_err   <= 1'b0;
            lsu_rdata <= 32'h0;
            unique case (state)
                IDLE: begin
                    if (lsu_ren || lsu_wen) begin
                        if (req_bad) begin
                            state    <= RESP;
                            lsu_done <= 1'b1;
                            lsu_err  <= 1'b1;
                        end else begin
                            state     <= REQ;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= lsu_wen;
                            mem_addr  <= {req_addr_al[31:2], 2'b00};
                            mem_be    <= req_be;
                            mem_wdata <= req_wdata;
                            lane      <= req_addr_al[1:0];
                            size      <= lsu_type;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        cnt     <= '0;
                        if (mem_we) begin
                            state    <= RESP;
                            lsu_done <= 1'b1;
                        end else begin
                            state <= WAIT_RVALID;
                        end
                    end else if (cnt == CNT_LAST) begin
                        mem_req  <= 1'b0;
                        state    <= RESP;
                        lsu_done <= 1'b1;
                        lsu_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_RVALID: begin
                    if (mem_rvalid) begin
                        state     <= RESP;
                        lsu_done  <= 1'b1;
                        lsu_rdata <= rd_ext;
                    end else if (cnt == CNT_LAST) begin
                        state    <= RESP;
                        lsu_done <= 1'b1;
                        lsu_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_responder.sv
// Randomized self-checking bench for lsu_responder against a byte-lane model.
// Build with LSU_RESP_MISALIGN_EN to match a design built the same way.
module tb_lsu_responder;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        lsu_ren;
    logic        lsu_wen;
    logic [1:0]  lsu_type;
    logic [31:0] lsu_addr_base;
    logic [31:0] lsu_addr_offset;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lsu_responder #(.TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .lsu_ren         (lsu_ren),
        .lsu_wen         (lsu_wen),
        .lsu_type        (lsu_type),
        .lsu_addr_base   (lsu_addr_base),
        .lsu_addr_offset (lsu_addr_offset),
        .lsu_wdata       (lsu_wdata),
        .lsu_done        (lsu_done),
        .lsu_rdata       (lsu_rdata),
        .lsu_err         (lsu_err),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_be          (mem_be),
        .mem_wdata       (mem_wdata),
        .mem_gnt         (mem_gnt),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".done"}, 32'(lsu_done), 32'd0);
        check({tag, ".req"},  32'(mem_req),  32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".done"},  32'(lsu_done),  32'd0);
        check({tag, ".err"},   32'(lsu_err),   32'd0);
        check({tag, ".rdata"}, lsu_rdata,      32'd0);
        check({tag, ".req"},   32'(mem_req),   32'd0);
        check({tag, ".we"},    32'(mem_we),    32'd0);
        check({tag, ".addr"},  mem_addr,       32'd0);
        check({tag, ".be"},    32'(mem_be),    32'd0);
        check({tag, ".wdata"}, mem_wdata,      32'd0);
    endtask

    // Called at a negedge; drops the request and lets n idle cycles pass.
    task automatic idle(input int n);
        lsu_ren    = 1'b0;
        lsu_wen    = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check_quiet("idle");
        end
    endtask

    // Called at a negedge. b2b=1 means the previous transaction's done
    // cycle is in progress and the request is presented during it.
    // gd: cycles before gnt; rd: cycles after gnt cycle before rvalid.
    // gd/rd >= TO means the memory never answers.
    task automatic txn(input bit b2b, input bit ren, input bit wen,
                       input logic [1:0] typ, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wd,
                       input int gd, input int rd, input logic [31:0] word);
        logic [31:0] a;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] erd;
        int          sz;
        int          lo;
        int          lat;
        int          req_last;
        bit          bad;
        bit          is_wr;
        bit          eerr;

        a     = base + off;
        sz    = (typ == 2'd0) ? 1 : (typ == 2'd1) ? 2 : 4;
        bad   = (ren && wen) || (typ == 2'b11);
        is_wr = wen && !ren;
        if (!bad && (int'(a[1:0]) % sz) != 0) begin
`ifdef LSU_RESP_MISALIGN_EN
            bad = 1'b1;
`else
            a = a & ~(32'(sz) - 32'd1);
`endif
        end
        lo  = int'(a[1:0]);
        ebe = 4'h0;
        ewd = 32'h0;
        erd = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i >= lo && i < lo + sz)
                ebe[i] = 1'b1;
            ewd[8*i +: 8] = wd[8*(i % sz) +: 8];
        end
        if (!bad)
            for (int j = 0; j < sz; j++)
                erd[8*j +: 8] = word[8*(lo + j) +: 8];

        if (bad) begin
            lat = 0; eerr = 1'b1; erd = 32'h0; req_last = -1;
        end else if (gd >= TO) begin
            lat = TO; eerr = 1'b1; erd = 32'h0; req_last = TO - 1;
        end else begin
            req_last = gd;
            if (is_wr) begin
                lat = gd + 1; eerr = 1'b0; erd = 32'h0;
            end else if (rd >= TO) begin
                lat = gd + 1 + TO; eerr = 1'b1; erd = 32'h0;
            end else begin
                lat = gd + 2 + rd; eerr = 1'b0;
            end
        end

        lsu_ren         = ren;
        lsu_wen         = wen;
        lsu_type        = typ;
        lsu_addr_base   = base;
        lsu_addr_offset = off;
        lsu_wdata       = wd;
        mem_gnt         = 1'b0;
        mem_rvalid      = 1'b0;
        if (b2b) begin
            @(posedge clk);
            @(negedge clk);
            check_quiet("gap");
        end
        @(posedge clk);
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            check("done", 32'(lsu_done), 32'(k == lat));
            check("mem_req", 32'(mem_req), 32'(k <= req_last));
            if (k == 0 && !bad) begin
                check("mem_addr", mem_addr, {a[31:2], 2'b00});
                check("mem_be", 32'(mem_be), 32'(ebe));
                check("mem_we", 32'(mem_we), 32'(is_wr));
                if (is_wr)
                    check("mem_wdata", mem_wdata, ewd);
            end
            mem_gnt    = !bad && gd < TO && k == gd;
            mem_rvalid = !bad && !is_wr && gd < TO && rd < TO
                         && k == gd + 1 + rd;
            mem_rdata  = mem_rvalid ? word : $urandom;
        end
        check("err", 32'(lsu_err), 32'(eerr));
        check("rdata", lsu_rdata, erd);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        lsu_ren         = 1'b0;
        lsu_wen         = 1'b0;
        lsu_type        = 2'b00;
        lsu_addr_base   = 32'h0;
        lsu_addr_offset = 32'h0;
        lsu_wdata       = 32'h0;
        mem_gnt         = 1'b0;
        mem_rvalid      = 1'b0;
        mem_rdata       = 32'h0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // First edge after release samples the word read.
        txn(0, 1, 0, 2'b10, 32'h1000, 32'h8, 32'h0, 0, 0, 32'hDEADBEEF);
        idle(2);
        txn(0, 0, 1, 2'b00, 32'h2000, 32'h3, 32'h000000A5, 0, 0, 32'h0);
        idle(2);
        txn(0, 1, 0, 2'b01, 32'h2000, 32'h2, 32'h0, 0, 0, 32'h12345678);
        idle(2);

        for (int i = 0; i < 12; i++)
            txn(i != 0, 1, 0, 2'b10, 32'h3000, 32'(4 * i), 32'h0,
                0, 0, $urandom);
        idle(2);

        txn(0, 1, 0, 2'b10, 32'h5000, 32'h0, 32'h0, TO, 0, 32'h0);
        lsu_ren    = 1'b0;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        repeat (3) begin
            @(negedge clk);
            check_quiet("stray");
            check("stray.rdata", lsu_rdata, 32'h0);
        end
        idle(1);

        txn(0, 1, 0, 2'b10, 32'h1000, 32'h2, 32'h0, 0, 0, 32'h89ABCDEF);
        idle(2);
        txn(0, 1, 1, 2'b10, 32'h1000, 32'h0, 32'h0, 0, 0, 32'h0);
        idle(2);
        txn(0, 1, 0, 2'b11, 32'h1000, 32'h0, 32'h0, 0, 0, 32'h0);
        idle(2);

        lsu_ren         = 1'b1;
        lsu_type        = 2'b10;
        lsu_addr_base   = 32'h4000;
        lsu_addr_offset = 32'h0;
        @(posedge clk);
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rst.pre_addr", mem_addr, 32'h4000);
        #2 rst_n = 1'b0;
        lsu_ren = 1'b0;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        txn(0, 1, 0, 2'b10, 32'h4010, 32'h0, 32'h0, 0, 1, 32'h0BADF00D);

        for (int n = 0; n < 60; n++) begin
            int          r;
            bit          ren;
            bit          wen;
            logic [1:0]  typ;
            int          gd;
            int          rd;
            bit          b2b;
            r   = $urandom_range(0, 9);
            typ = (r == 0) ? 2'b11 : 2'(r % 3);
            r   = $urandom_range(0, 9);
            ren = (r < 5);
            wen = (r == 0) || (r >= 5);
            gd  = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 2)
                                               : $urandom_range(0, 3);
            rd  = ($urandom_range(0, 15) == 0) ? TO + $urandom_range(0, 2)
                                               : $urandom_range(0, 3);
            b2b = $urandom_range(0, 1) == 1;
            if (!b2b)
                idle($urandom_range(1, 3));
            txn(b2b, ren, wen, typ, $urandom, $urandom, $urandom,
                gd, rd, $urandom);
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
